// File: rtl/bram_port_arb.sv
// Two-requester arbiter in front of a single BRAM port.
// Handles lock bursts with a burst cap and returns read data in acceptance order.
module bram_port_arb #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int PIPELINED  = 0,
  parameter int MAX_BURST  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0_VALID,
  output logic                  REQ0_READY,
  input  logic                  REQ0_WE,
  input  logic                  REQ0_LOCK,
  input  logic [ADDR_WIDTH-1:0] REQ0_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ0_DATA,
  input  logic                  REQ1_VALID,
  output logic                  REQ1_READY,
  input  logic                  REQ1_WE,
  input  logic                  REQ1_LOCK,
  input  logic [ADDR_WIDTH-1:0] REQ1_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ1_DATA,
  output logic                  RSP0_VALID,
  output logic                  RSP1_VALID,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  output logic                  BRAM_EN,
  output logic                  BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [DATA_WIDTH-1:0] BRAM_DI,
  input  logic [DATA_WIDTH-1:0] BRAM_DO
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] MAXB = 8'(MAX_BURST);

  state_t     state, state_nx;
  logic       last_grant, last_nx;
  logic [7:0] cnt, cnt_nx;
  logic       g0, g1;
  logic       acc;
  logic       at_max;
  logic       t1_v, t1_id;
  logic       tail_v, tail_id;

  assign at_max = (cnt == MAXB);

  // State, burst counter and tie-break history
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      last_grant <= last_nx;
    end
  end

  // Grant selection and next-state; a capped owner yields to a waiting peer
  always_comb begin
    g0       = 1'b0;
    g1       = 1'b0;
    state_nx = state;
    cnt_nx   = cnt;
    last_nx  = last_grant;
    unique case (state)
      IDLE: begin
        if (REQ0_VALID && (!REQ1_VALID || last_grant)) g0 = 1'b1;
        else if (REQ1_VALID)                          g1 = 1'b1;
      end
      OWN0: begin
        if (at_max && REQ1_VALID) g1 = 1'b1;
        else if (REQ0_VALID)      g0 = 1'b1;
      end
      OWN1: begin
        if (at_max && REQ0_VALID) g0 = 1'b1;
        else if (REQ1_VALID)      g1 = 1'b1;
      end
      default: ;
    endcase
    if (RST) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end
    if (g0) begin
      last_nx = 1'b0;
      if (REQ0_LOCK) begin
        state_nx = OWN0;
        if (state == OWN0) cnt_nx = at_max ? cnt : cnt + 8'd1;
        else               cnt_nx = 8'd1;
      end else begin
        state_nx = IDLE;
        cnt_nx   = 8'd0;
      end
    end else if (g1) begin
      last_nx = 1'b1;
      if (REQ1_LOCK) begin
        state_nx = OWN1;
        if (state == OWN1) cnt_nx = at_max ? cnt : cnt + 8'd1;
        else               cnt_nx = 8'd1;
      end else begin
        state_nx = IDLE;
        cnt_nx   = 8'd0;
      end
    end else begin
      state_nx = IDLE;
      cnt_nx   = 8'd0;
    end
  end

  assign REQ0_READY = g0;
  assign REQ1_READY = g1;
  assign acc        = g0 | g1;

  // Steer the granted request onto the BRAM port, zero when idle
  always_comb begin
    BRAM_EN   = acc;
    BRAM_WE   = 1'b0;
    BRAM_ADDR = '0;
    BRAM_DI   = '0;
    if (g0) begin
      BRAM_WE   = REQ0_WE;
      BRAM_ADDR = REQ0_ADDR;
      BRAM_DI   = REQ0_DATA;
    end else if (g1) begin
      BRAM_WE   = REQ1_WE;
      BRAM_ADDR = REQ1_ADDR;
      BRAM_DI   = REQ1_DATA;
    end
  end

  // First tag stage records which requester issued a read this cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      t1_v  <= 1'b0;
      t1_id <= 1'b0;
    end else begin
      t1_v  <= acc & ~BRAM_WE;
      t1_id <= g1;
    end
  end

  generate
    if (PIPELINED != 0) begin : g_l2
      logic t2_v, t2_id;
      // Second tag stage matches the BRAM output register
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          t2_v  <= 1'b0;
          t2_id <= 1'b0;
        end else begin
          t2_v  <= t1_v;
          t2_id <= t1_id;
        end
      end
      assign tail_v  = t2_v;
      assign tail_id = t2_id;
    end else begin : g_l1
      assign tail_v  = t1_v;
      assign tail_id = t1_id;
    end
  endgenerate

  assign RSP0_VALID = tail_v & ~tail_id;
  assign RSP1_VALID = tail_v & tail_id;
  assign RSP_DATA   = tail_v ? BRAM_DO : '0;

endmodule

// File: tb/tb_bram_port_arb.sv
// Bench for bram_port_arb: two instances (L=1/burst 2, L=2/burst 3)
// share random and directed stimulus and are checked against a reference model.
module tb_bram_port_arb;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       clr = 1'b1;

  logic [1:0] rv, rwe, rlk;
  logic [3:0] ra [2];
  logic [7:0] rd [2];

  logic [1:0] sv, swe, slk;
  logic [3:0] sa [2];
  logic [7:0] sd [2];

  logic [1:0] rdy0, rdy1, rsp0, rsp1, ben, bwe;
  logic [7:0] rdata [2];
  logic [3:0] baddr [2];
  logic [7:0] bdi   [2];
  logic [7:0] bdo   [2];

  logic [7:0] mem [2][16];
  logic [7:0] d1  [2];
  logic [7:0] d2  [2];

  always #5 CLK = ~CLK;

  bram_port_arb #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .PIPELINED(0), .MAX_BURST(2)
  ) u_l1 (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(rv[0]), .REQ0_READY(rdy0[0]), .REQ0_WE(rwe[0]),
    .REQ0_LOCK(rlk[0]), .REQ0_ADDR(ra[0]), .REQ0_DATA(rd[0]),
    .REQ1_VALID(rv[1]), .REQ1_READY(rdy1[0]), .REQ1_WE(rwe[1]),
    .REQ1_LOCK(rlk[1]), .REQ1_ADDR(ra[1]), .REQ1_DATA(rd[1]),
    .RSP0_VALID(rsp0[0]), .RSP1_VALID(rsp1[0]), .RSP_DATA(rdata[0]),
    .BRAM_EN(ben[0]), .BRAM_WE(bwe[0]), .BRAM_ADDR(baddr[0]),
    .BRAM_DI(bdi[0]), .BRAM_DO(bdo[0])
  );

  bram_port_arb #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .PIPELINED(1), .MAX_BURST(3)
  ) u_l2 (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(rv[0]), .REQ0_READY(rdy0[1]), .REQ0_WE(rwe[0]),
    .REQ0_LOCK(rlk[0]), .REQ0_ADDR(ra[0]), .REQ0_DATA(rd[0]),
    .REQ1_VALID(rv[1]), .REQ1_READY(rdy1[1]), .REQ1_WE(rwe[1]),
    .REQ1_LOCK(rlk[1]), .REQ1_ADDR(ra[1]), .REQ1_DATA(rd[1]),
    .RSP0_VALID(rsp0[1]), .RSP1_VALID(rsp1[1]), .RSP_DATA(rdata[1]),
    .BRAM_EN(ben[1]), .BRAM_WE(bwe[1]), .BRAM_ADDR(baddr[1]),
    .BRAM_DI(bdi[1]), .BRAM_DO(bdo[1])
  );

  // Write-first BRAM plants, one per instance
  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        for (int i = 0; i < 16; i++) mem[k][i] <= 8'h00;
        d1[k] <= 8'h00;
        d2[k] <= 8'h00;
      end else begin
        if (ben[k]) begin
          if (bwe[k]) begin
            mem[k][baddr[k]] <= bdi[k];
            d1[k] <= bdi[k];
          end else begin
            d1[k] <= mem[k][baddr[k]];
          end
        end
        d2[k] <= d1[k];
      end
    end
  end

  assign bdo[0] = d1[0];
  assign bdo[1] = d2[1];

  typedef struct {
    int         inst;
    int         id;
    logic [7:0] data;
    int         due;
  } rsp_t;

  rsp_t       pend [$];
  int         own  [2];
  int         cnt  [2];
  int         last [2];
  int         mb   [2];
  int         lat  [2];
  logic [7:0] refm [2][16];
  int         gobs [2];
  int         cyc;
  int         n_vec;
  int         n_err;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    own[k]  = -1;
    cnt[k]  = 0;
    last[k] = 1;
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i].inst == k) pend.delete(i);
  endtask

  // Check one instance for this cycle, then advance its model
  task automatic eval_inst(input int k, input logic rs);
    int         eg, x, o, hit;
    logic       e_we, e_r0, e_r1;
    logic [3:0] e_a;
    logic [7:0] e_d, e_rd;
    string      p;
    p  = $sformatf("u%0d", k);
    eg = -1;
    if (rs) model_reset(k);
    else if (own[k] < 0) begin
      if (rv[0] && rv[1]) eg = (last[k] == 1) ? 0 : 1;
      else if (rv[0])     eg = 0;
      else if (rv[1])     eg = 1;
    end else begin
      x = own[k];
      o = 1 - x;
      if (cnt[k] == mb[k] && rv[o]) eg = o;
      else if (rv[x])              eg = x;
    end
    e_we = (eg >= 0) ? rwe[eg] : 1'b0;
    e_a  = (eg >= 0) ? ra[eg]  : 4'h0;
    e_d  = (eg >= 0) ? rd[eg]  : 8'h0;
    hit  = -1;
    for (int i = 0; i < pend.size(); i++)
      if (pend[i].inst == k && pend[i].due == cyc) hit = i;
    e_r0 = (hit >= 0) && (pend[hit].id == 0);
    e_r1 = (hit >= 0) && (pend[hit].id == 1);
    e_rd = (hit >= 0) ? pend[hit].data : 8'h00;
    if (hit >= 0) pend.delete(hit);
    chk({p, ".ready0"}, 32'(rdy0[k]), 32'(eg == 0));
    chk({p, ".ready1"}, 32'(rdy1[k]), 32'(eg == 1));
    chk({p, ".bram_en"}, 32'(ben[k]), 32'(eg >= 0));
    chk({p, ".bram_we"}, 32'(bwe[k]), 32'(e_we));
    chk({p, ".bram_addr"}, 32'(baddr[k]), 32'(e_a));
    chk({p, ".bram_di"}, 32'(bdi[k]), 32'(e_d));
    chk({p, ".rsp0"}, 32'(rsp0[k]), 32'(e_r0));
    chk({p, ".rsp1"}, 32'(rsp1[k]), 32'(e_r1));
    chk({p, ".rsp_data"}, 32'(rdata[k]), 32'(e_rd));
    gobs[k] = rdy0[k] ? 0 : (rdy1[k] ? 1 : -1);
    if (!rs && eg >= 0) begin
      if (!rwe[eg]) pend.push_back('{k, eg, refm[k][ra[eg]], cyc + lat[k]});
      else refm[k][ra[eg]] = rd[eg];
      last[k] = eg;
      if (!rlk[eg]) begin
        own[k] = -1;
        cnt[k] = 0;
      end else if (own[k] == eg) begin
        if (cnt[k] < mb[k]) cnt[k]++;
      end else begin
        own[k] = eg;
        cnt[k] = 1;
      end
    end else if (!rs) begin
      own[k] = -1;
      cnt[k] = 0;
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic we,
                         input logic lk, input logic [3:0] a,
                         input logic [7:0] d);
    sv[id]  = v;
    swe[id] = we;
    slk[id] = lk;
    sa[id]  = a;
    sd[id]  = d;
  endtask

  task automatic idle_req();
    set_req(0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    set_req(1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic tick(input logic rs);
    @(negedge CLK);
    clr = 1'b0;
    RST = rs;
    rv  = sv;
    rwe = swe;
    rlk = slk;
    ra  = sa;
    rd  = sd;
    #1;
    eval_inst(0, rs);
    eval_inst(1, rs);
    cyc++;
  endtask

  initial begin
    int exp_g [6];
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    mb[0] = 2;
    mb[1] = 3;
    lat[0] = 1;
    lat[1] = 2;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) refm[k][i] = 8'h00;
      model_reset(k);
    end
    rv = '0; rwe = '0; rlk = '0;
    ra[0] = '0; ra[1] = '0; rd[0] = '0; rd[1] = '0;
    idle_req();

    // Reset state
    tick(1'b1);
    chk("rst.rsp0", 32'(rsp0), 32'h0);
    chk("rst.rsp1", 32'(rsp1), 32'h0);

    // Tie, no lock: alternating grants, one-cycle responses on u_l1
    set_req(0, 1'b1, 1'b1, 1'b0, 4'd3, 8'h33);
    tick(1'b0);
    idle_req();
    set_req(1, 1'b1, 1'b1, 1'b0, 4'd5, 8'h55);
    tick(1'b0);
    idle_req();
    tick(1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        set_req(0, 1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
        set_req(1, 1'b1, 1'b0, 1'b0, 4'd5, 8'h00);
      end else idle_req();
      tick(1'b0);
      if (i < 4) chk($sformatf("tie.g%0d", i), 32'(gobs[0]), 32'(i % 2));
      if (i > 0) chk($sformatf("tie.d%0d", i), 32'(rdata[0]),
                     (i % 2 == 1) ? 32'h33 : 32'h55);
    end

    // Burst cap of 2 on u_l1 with requester 1 waiting
    idle_req();
    tick(1'b1);
    exp_g = '{0, 0, 1, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin
      set_req(0, 1'b1, 1'b0, 1'b1, 4'($urandom_range(15)), 8'h00);
      set_req(1, 1'b1, 1'b0, 1'b0, 4'($urandom_range(15)), 8'h00);
      tick(1'b0);
      chk($sformatf("burst.g%0d", i), 32'(gobs[0]), 32'(exp_g[i]));
    end

    // Write then read of the same address on the two-cycle instance
    idle_req();
    tick(1'b1);
    set_req(0, 1'b1, 1'b1, 1'b0, 4'd7, 8'hA5);
    tick(1'b0);
    set_req(0, 1'b1, 1'b0, 1'b0, 4'd7, 8'h00);
    tick(1'b0);
    idle_req();
    tick(1'b0);
    chk("lat.early", 32'(rsp0[1]), 32'h0);
    tick(1'b0);
    chk("lat.rsp0", 32'(rsp0[1]), 32'h1);
    chk("lat.data", 32'(rdata[1]), 32'hA5);
    tick(1'b0);
    chk("lat.none", 32'(rsp0[1] | rsp1[1]), 32'h0);

    // Owner drops valid for a cycle while requester 0 waits
    tick(1'b1);
    set_req(1, 1'b1, 1'b0, 1'b1, 4'd2, 8'h00);
    tick(1'b0);
    set_req(1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    set_req(0, 1'b1, 1'b0, 1'b0, 4'd4, 8'h00);
    tick(1'b0);
    chk("drop.none0", 32'(gobs[0]), 32'hFFFF_FFFF);
    chk("drop.none1", 32'(gobs[1]), 32'hFFFF_FFFF);
    tick(1'b0);
    chk("drop.g0", 32'(gobs[0]), 32'h0);
    chk("drop.g1", 32'(gobs[1]), 32'h0);

    // Reset pulse while a read is in flight
    idle_req();
    tick(1'b1);
    set_req(0, 1'b1, 1'b0, 1'b0, 4'd7, 8'h00);
    tick(1'b0);
    idle_req();
    tick(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      chk($sformatf("rstrd.rsp%0d", i), 32'(rsp0[1] | rsp1[1]), 32'h0);
    end
    set_req(0, 1'b1, 1'b0, 1'b0, 4'd1, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b0, 4'd2, 8'h00);
    tick(1'b0);
    chk("rstrd.tie0", 32'(gobs[0]), 32'h0);
    chk("rstrd.tie1", 32'(gobs[1]), 32'h0);

    // Random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      for (int id = 0; id < 2; id++)
        set_req(id, 1'($urandom_range(3) != 0), 1'($urandom_range(2) == 0),
                1'($urandom_range(1)), 4'($urandom_range(15)),
                8'($urandom_range(255)));
      tick(1'($urandom_range(49) == 0));
    end
    idle_req();
    for (int n = 0; n < 3; n++) tick(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_port_arb.md
BRAM_PORT_ARB -- requirements
Module: bram_port_arb

Interface
REQ-001 The module SHALL have these parameters, one per line (name, default, meaning):
- ADDR_WIDTH, 1, BRAM address width.
- DATA_WIDTH, 1, BRAM data width.
- PIPELINED, 0, BRAM output register mode: 0 gives read latency L=1, 1 gives L=2.
- MAX_BURST, 4, maximum consecutive locked grants while the other requester waits; legal range 1 to 255.
REQ-002 The module SHALL have these ports, one per line (name, direction, width, meaning):
- CLK, in, 1, the single clock; all state updates on the rising edge.
- RST, in, 1, asynchronous, active-high reset.
- REQ0_VALID, in, 1, requester 0 has a request.
- REQ0_READY, out, 1, requester 0 request accepted this cycle.
- REQ0_WE, in, 1, 1 = write, 0 = read.
- REQ0_LOCK, in, 1, requester 0 wants to keep ownership after this request.
- REQ0_ADDR, in, ADDR_WIDTH, requester 0 address.
- REQ0_DATA, in, DATA_WIDTH, requester 0 write data.
- REQ1_VALID, REQ1_READY, REQ1_WE, REQ1_LOCK, REQ1_ADDR, REQ1_DATA: same as the REQ0 ports, for requester 1.
- RSP0_VALID, out, 1, read data for requester 0 is on RSP_DATA.
- RSP1_VALID, out, 1, read data for requester 1 is on RSP_DATA.
- RSP_DATA, out, DATA_WIDTH, read return data.
- BRAM_EN, out, 1, port enable to the BRAM.
- BRAM_WE, out, 1, port write enable to the BRAM.
- BRAM_ADDR, out, ADDR_WIDTH, port address to the BRAM.
- BRAM_DI, out, DATA_WIDTH, port write data to the BRAM.
- BRAM_DO, in, DATA_WIDTH, port read data from the BRAM, already delayed L cycles by the BRAM.

Function
REQ-003 A request SHALL be accepted when REQx_VALID and REQx_READY are both 1 in the same cycle. At most one request SHALL be accepted per cycle.
REQ-004 REQx_READY and the BRAM_* outputs SHALL be combinational from the current state and the REQ inputs.
REQ-005 On an accepted request: BRAM_EN=1, and BRAM_WE, BRAM_ADDR and BRAM_DI SHALL carry the granted requester's WE, ADDR and DATA.
REQ-006 With no accepted request: BRAM_EN, BRAM_WE, BRAM_ADDR and BRAM_DI SHALL all be 0.
REQ-007 The FSM SHALL have three states: IDLE, OWN0 and OWN1. It SHALL keep a last_grant bit and an 8-bit burst counter cnt.
REQ-008 In IDLE, with exactly one VALID, that requester SHALL be granted.
REQ-009 In IDLE, with both VALID, the requester that is not last_grant SHALL be granted.
REQ-010 In IDLE, a grant with LOCK=1 SHALL move the FSM to OWNx with cnt=1. A grant with LOCK=0 SHALL leave the FSM in IDLE.
REQ-011 In OWNx, only requester x SHALL be eligible. The other requester's READY SHALL be 0, except in the case of REQ-014.
REQ-012 In OWNx with REQx_VALID=1 and cnt<MAX_BURST: grant x. If LOCK=1, stay in OWNx and increment cnt. If LOCK=0, go to IDLE.
REQ-013 In OWNx with REQx_VALID=0: no grant that cycle; the next state SHALL be IDLE.
REQ-014 In OWNx with cnt==MAX_BURST and the other requester VALID: x SHALL NOT be granted. The other requester SHALL be granted, and its LOCK SHALL select the next state as in REQ-010.
REQ-015 In OWNx with cnt==MAX_BURST and the other requester not VALID: x SHALL still be granted per REQ-012, and cnt SHALL hold at MAX_BURST.
REQ-016 last_grant SHALL be updated to the granted id on every grant.
REQ-017 A tag pipeline of L stages SHALL track accepted reads. Stage 1 SHALL load {accepted & ~WE, id} every cycle. When L=2, stage 2 SHALL load stage 1.
REQ-018 A read accepted in cycle n SHALL produce RSPid_VALID=1 in cycle n+L, with RSP_DATA=BRAM_DO in that cycle.
REQ-019 When neither RSP valid is asserted, RSP_DATA SHALL be 0.
REQ-020 Writes SHALL produce no response.
REQ-021 Responses have no backpressure; the requester SHALL accept RSP whenever it is asserted.
REQ-022 Sustained throughput SHALL be one request per cycle. Responses SHALL return in acceptance order.
REQ-023 A read accepted one cycle after a write to the same address SHALL return the written data. This follows from BRAM write-first behaviour and needs no forwarding in this block.

Reset
REQ-024 When RST=1, asynchronously: state=IDLE, cnt=0, last_grant=1 (so requester 0 wins the first tie), all tag stages invalid.
REQ-025 During reset, RSP0_VALID, RSP1_VALID and RSP_DATA SHALL be 0, and both READYs SHALL be 0.
REQ-026 Reads in flight when reset asserts SHALL be discarded; no RSP SHALL appear for them after reset deasserts.

Verification
REQ-027 Tie with PIPELINED=0: both requesters issue reads, LOCK=0, ADDR0=3, ADDR1=5, both held VALID for 4 cycles. Required: grants alternate 0,1,0,1; each RSP arrives 1 cycle after its grant with the matching data.
REQ-028 Burst limit with MAX_BURST=2: R0 holds LOCK=1 and VALID continuously while R1 is VALID. Required grant sequence: 0,0,1,0,0,1.
REQ-029 Latency with PIPELINED=1: a write of 0xA5 to address 7 is followed next cycle by a read of address 7. Required: RSP0_VALID and RSP_DATA=0xA5 exactly 2 cycles after the read grant; no response for the write.
REQ-030 Owner drop: in OWN1, R1 deasserts VALID for 1 cycle while R0 is VALID. Required: no grant in that cycle; R0 granted in the following cycle from IDLE.
REQ-031 Reset mid-read: RST pulses for 1 cycle in the cycle after a read is accepted (PIPELINED=1). Required: RSP0_VALID and RSP1_VALID stay 0; the FSM is in IDLE; the first tie after reset grants R0.
